// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: stage indices,
// canonical stall vectors, FSM state encoding and default latency.
package pipe_ctrl_pkg;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;
  localparam int NUM_STG = 6;

  // Stall vectors are always contiguous from the PC stage upward.
  localparam logic [NUM_STG-1:0] STALL_NONE = 6'b000000;
  localparam logic [NUM_STG-1:0] STALL_ID   = 6'b000111;
  localparam logic [NUM_STG-1:0] STALL_EX   = 6'b001111;

  localparam int MC_CYCLES_DEF = 32;
  localparam int CNT_W_DEF     = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MC_RUN  = 2'd1,
    ST_MC_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_mc_counter.sv
// Multi-cycle-op latency counter: synchronous clear, load and decrement,
// with a terminal-count flag raised when the count reaches one.
module mc_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear beats load beats decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges load-use, multi-cycle EX and MEM
// flush requests into a per-stage stall vector, flush pulse and redirect PC.
// Build option PIPE_CTRL_STALL_CNT_EN adds a free-running stalled-cycle
// counter on stall_cycles; without it that port reads zero.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_CYCLES = MC_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stallreq,
  input  logic        ex_mc_start,
  output logic        ex_mc_done,
  input  logic        flush_req,
  input  logic [31:0] flush_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        busy,
  output logic [31:0] stall_cycles
);

  state_e state_q;
  state_e state_d;
  logic   cnt_clr;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_tc;

  mc_counter #(
    .CNT_W (CNT_W)
  ) u_mc_counter (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (CNT_W'(MC_CYCLES - 1)),
    .tc_o       (cnt_tc)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counter control and stall/flush outputs; flush wins over
  // the multi-cycle stall, which wins over load-use. Outputs are held at
  // their idle values while reset is asserted.
  always_comb begin
    state_d    = state_q;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    stall      = STALL_NONE;
    flush      = 1'b0;
    new_pc     = '0;
    ex_mc_done = 1'b0;
    if (rst) begin
      state_d = ST_IDLE;
    end else if (flush_req) begin
      flush   = 1'b1;
      new_pc  = flush_pc;
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ex_mc_start) begin
            stall    = STALL_EX;
            cnt_load = 1'b1;
            state_d  = ST_MC_RUN;
          end else if (id_stallreq) begin
            stall = STALL_ID;
          end
        end
        ST_MC_RUN: begin
          // id is already held by the EX stall, so load-use is moot here.
          stall = STALL_EX;
          if (cnt_tc) begin
            state_d = ST_MC_DONE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_MC_DONE: begin
          // ex_mc_start is not looked at: it still reflects the departing op.
          ex_mc_done = 1'b1;
          if (id_stallreq) begin
            stall = STALL_ID;
          end
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q != ST_IDLE);

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Stalled-cycle count, wrapping modulo 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall != STALL_NONE) && !flush) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stalled-cycle register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl with a 4-cycle multi-cycle latency.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        id_stallreq;
  logic        ex_mc_start;
  logic        ex_mc_done;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        busy;
  logic [31:0] stall_cycles;

  pipe_ctrl #(
    .MC_CYCLES (4),
    .CNT_W     (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_stallreq  (id_stallreq),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_done   (ex_mc_done),
    .flush_req    (flush_req),
    .flush_pc     (flush_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .busy         (busy),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic        st;
    logic        fr;
    logic [31:0] pc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_npc;
    logic        e_done;
    logic        e_busy;
  } vec_t;

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SI = 6'b000111;
  localparam logic [5:0] SE = 6'b001111;

  vec_t        q[$];
  vec_t        tbl[$];
  vec_t        e;
  int          n_chk = 0;
  int          n_err = 0;
  int          row   = 0;
  logic [31:0] sc_exp = 0;

  function automatic vec_t mk(input logic id, input logic st, input logic fr,
                              input logic [31:0] pc, input logic [5:0] es,
                              input logic ef, input logic ed, input logic eb);
    vec_t v;
    v.id = id; v.st = st; v.fr = fr; v.pc = pc;
    v.e_stall = es; v.e_flush = ef; v.e_done = ed; v.e_busy = eb;
    v.e_npc = ef ? pc : 32'h0;
    return v;
  endfunction

  task automatic chk(input string nm, input int r, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, r, act, exp);
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge and queue its
  // expected outputs.
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    id_stallreq = v.id;
    ex_mc_start = v.st;
    flush_req   = v.fr;
    flush_pc    = v.pc;
    q.push_back(v);
  endtask

  // Scoreboard: outputs are combinational, so each queued row is compared
  // on the falling edge of the cycle it was driven in.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("stall", row, {26'h0, stall}, {26'h0, e.e_stall});
      chk("flush", row, {31'h0, flush}, {31'h0, e.e_flush});
      chk("new_pc", row, new_pc, e.e_npc);
      chk("ex_mc_done", row, {31'h0, ex_mc_done}, {31'h0, e.e_done});
      chk("busy", row, {31'h0, busy}, {31'h0, e.e_busy});
`ifdef PIPE_CTRL_STALL_CNT_EN
      chk("stall_cycles", row, stall_cycles, sc_exp);
      if (e.e_stall != S0 && !e.e_flush) sc_exp = sc_exp + 32'd1;
`else
      chk("stall_cycles", row, stall_cycles, 32'h0);
`endif
      row++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; id_stallreq = 1'b0; ex_mc_start = 1'b0;
    flush_req = 1'b0; flush_pc = 32'h0;
    #3;
    chk("rst_stall", -1, {26'h0, stall}, 32'h0);
    chk("rst_flush", -1, {31'h0, flush}, 32'h0);
    chk("rst_new_pc", -1, new_pc, 32'h0);
    chk("rst_done", -1, {31'h0, ex_mc_done}, 32'h0);
    chk("rst_busy", -1, {31'h0, busy}, 32'h0);
    chk("rst_stall_cycles", -1, stall_cycles, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single-cycle behaviour table: load-use, flush in IDLE, flush+start.
    tbl.push_back(mk(0, 0, 0, 32'h0,   S0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,   SI, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,   SI, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   S0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 32'h200, S0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h300, S0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   S0, 0, 0, 0));
    foreach (tbl[i]) apply(tbl[i]);

    // Multi-cycle op t..t+4, back-to-back op t+5..t+9 with load-use in DONE.
    apply(mk(0, 1, 0, 32'h0, SE, 0, 0, 0));
    apply(mk(0, 1, 0, 32'h0, SE, 0, 0, 1));
    apply(mk(1, 1, 0, 32'h0, SE, 0, 0, 1));
    apply(mk(0, 1, 0, 32'h0, SE, 0, 0, 1));
    apply(mk(0, 1, 0, 32'h0, S0, 0, 1, 1));
    apply(mk(0, 1, 0, 32'h0, SE, 0, 0, 0));
    apply(mk(0, 1, 0, 32'h0, SE, 0, 0, 1));
    apply(mk(0, 1, 0, 32'h0, SE, 0, 0, 1));
    apply(mk(0, 1, 0, 32'h0, SE, 0, 0, 1));
    apply(mk(1, 0, 0, 32'h0, SI, 0, 1, 1));
    apply(mk(1, 0, 0, 32'h0, SI, 0, 0, 0));
    apply(mk(0, 0, 0, 32'h0, S0, 0, 0, 0));

    // Flush in the third cycle of a run: no done pulse afterwards.
    apply(mk(0, 1, 0, 32'h0,   SE, 0, 0, 0));
    apply(mk(0, 1, 0, 32'h0,   SE, 0, 0, 1));
    apply(mk(0, 1, 1, 32'h100, S0, 1, 0, 1));
    apply(mk(0, 0, 0, 32'h0,   S0, 0, 0, 0));
    apply(mk(0, 0, 0, 32'h0,   S0, 0, 0, 0));
    apply(mk(0, 0, 0, 32'h0,   S0, 0, 0, 0));

    // Flush in the DONE cycle suppresses the done pulse.
    apply(mk(0, 1, 0, 32'h0,   SE, 0, 0, 0));
    apply(mk(0, 1, 0, 32'h0,   SE, 0, 0, 1));
    apply(mk(0, 1, 0, 32'h0,   SE, 0, 0, 1));
    apply(mk(0, 1, 0, 32'h0,   SE, 0, 0, 1));
    apply(mk(0, 0, 1, 32'h400, S0, 1, 0, 1));
    apply(mk(0, 0, 0, 32'h0,   S0, 0, 0, 0));

    // Reset asserted mid-run.
    apply(mk(0, 1, 0, 32'h0, SE, 0, 0, 0));
    apply(mk(0, 1, 0, 32'h0, SE, 0, 0, 1));
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_stall", -2, {26'h0, stall}, 32'h0);
    chk("arst_busy", -2, {31'h0, busy}, 32'h0);
    chk("arst_done", -2, {31'h0, ex_mc_done}, 32'h0);
    chk("arst_flush", -2, {31'h0, flush}, 32'h0);
    chk("arst_stall_cycles", -2, stall_cycles, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0; ex_mc_start = 1'b0; sc_exp = 0;
    apply(mk(0, 0, 0, 32'h0, S0, 0, 0, 0));
    apply(mk(0, 0, 0, 32'h0, S0, 0, 0, 0));
    apply(mk(1, 0, 0, 32'h0, SI, 0, 0, 0));
    apply(mk(0, 0, 0, 32'h0, S0, 0, 0, 0));

    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    #1;
    chk("queue_drained", -3, q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core.
- Merges the decode-stage load-use stall request, the EX multi-cycle (divide) operation and the MEM exception flush into one per-stage stall vector, a flush pulse and a redirect PC.
- Owns the multi-cycle-op latency counter.
- Tells EX on which cycle its multi-cycle result is ready.

Parameters:
MC_CYCLES, 32, stall cycles of an EX multi-cycle op; legal range 2..2^CNT_W-1.
CNT_W, 6, latency counter width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; asynchronous assert, active-high
id_stallreq  input  1  load-use hazard from decode; combinational, same-cycle
ex_mc_start  input  1  multi-cycle op present in EX; stays high while the op is held in EX
ex_mc_done  output  1  multi-cycle result valid this cycle; the op leaves EX at the end of this cycle
flush_req  input  1  exception or redirect from MEM
flush_pc  input  32  redirect target, valid with flush_req
stall  output  6  hold per stage: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb
flush  output  1  kill all in-flight stage registers this cycle
new_pc  output  32  PC to load when flush=1
busy  output  1  multi-cycle sequence in progress (state != IDLE)
stall_cycles  output  32  stalled-cycle count (see Optional Feature)

Behaviour:
- Reset values: state=IDLE, cnt=0, stall=0, flush=0, new_pc=0, ex_mc_done=0, busy=0, stall_cycles=0. Reset mid-sequence aborts the multi-cycle op immediately; no ex_mc_done pulse.
- FSM states: IDLE, MC_RUN, MC_DONE. State and cnt are registered; stall, flush and new_pc are combinational from state and inputs.
- IDLE:
  - ex_mc_start=1 and flush_req=0: load cnt=MC_CYCLES-1, go to MC_RUN; stall=6'b001111 in this same cycle.
- MC_RUN:
  - stall=6'b001111.
  - If cnt==1, go to MC_DONE; otherwise cnt decrements.
  - ex_mc_start and id_stallreq are ignored (the stall already covers id).
- MC_DONE:
  - ex_mc_done=1, stall released for EX; next state IDLE.
  - ex_mc_start is not sampled here, so the departing op cannot retrigger.
  - A back-to-back multi-cycle op starts no earlier than the following IDLE cycle.
- Latency: start sampled in cycle t gives stall=001111 for cycles t..t+MC_CYCLES-1 and ex_mc_done=1 in cycle t+MC_CYCLES.
- Load-use: in IDLE or MC_DONE with no multi-cycle stall, id_stallreq=1 gives stall=6'b000111 (pc, if, id held; bubble into ex).
- Stall priority: flush > multi-cycle > load-use > none (stall=0).
- Flush, any state:
  - flush=1, new_pc=flush_pc, stall=0, ex_mc_done forced 0.
  - Next state IDLE, cnt cleared.
  - ex_mc_start in the same cycle is discarded.
  - flush=0 implies new_pc=0.
- The stall vector is always contiguous from bit0; WB (bit5) is never stalled by this block.

Optional Feature:
Macro PIPE_CTRL_STALL_CNT_EN.
- Defined: 32-bit stall_cycles register, reset 0. Increments every cycle in which stall!=0 and flush=0; wraps modulo 2^32.
- Undefined: no register is built; stall_cycles is tied to 0.
- The port exists in both builds.

Decomposition:
- Shared package: stage index constants (STG_PC=0 .. STG_WB=5), stall vector constants STALL_NONE=6'b000000, STALL_ID=6'b000111 and STALL_EX=6'b001111, FSM state encoding, default MC_CYCLES.
- One natural sub-module: mc_counter (load/decrement/terminal-count, CNT_W wide).
- Stall/flush priority logic stays in pipe_ctrl.

Test Plan:
- Reset asserted mid-MC_RUN: outputs go to reset values asynchronously; after release, stall=0 and busy=0.
- id_stallreq=1 for 2 cycles in IDLE -> stall=000111 in exactly those cycles; ex_mc_done stays 0.
- MC_CYCLES=4, ex_mc_start held from cycle t -> stall=001111 in t..t+3, ex_mc_done=1 only in t+4, busy=1 in t+1..t+4.
- Back-to-back ops (ex_mc_start high in t+4 and t+5) -> second sequence starts at t+5; done pulses in t+4 and t+9.
- flush_req=1 with flush_pc=32'h0000_0100 in cycle t+2 of a run -> flush=1, new_pc=0x100, stall=0, ex_mc_done never pulses; IDLE at t+3.
- PIPE_CTRL_STALL_CNT_EN defined, scenario 3 plus one load-use cycle -> stall_cycles=5; macro undefined -> stall_cycles=0.
